// File: rtl/ascon_perm_core.sv
// Ascon permutation engine: p^a with a = 1..12, UNROLL rounds per clock, valid/ready on both sides.
// State lanes are packed x0 at [319:256] down to x4 at [63:0].
module ascon_perm_core #(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned BW     = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_state,
  input  logic [3:0]   in_rounds,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy
);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_core: UNROLL must be 1, 2, 3 or 4");
  end
  if (BW != 64) begin : g_bad_bw
    $error("ascon_perm_core: BW must be 64");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q;
  logic [319:0] st_q;
  logic [3:0]   k_q;
  logic [3:0]   rem_q;
  logic         out_valid_q;

  logic [3:0]   a_clamped;
  logic [3:0]   m;
  logic [3:0]   rem_next;
  logic [7:0]   stage_rc [UNROLL];
  logic [319:0] stage_last;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, rc};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Stages beyond the remaining round count pass the state through untouched.
  for (genvar j = 0; j < int'(UNROLL); j++) begin : g_stage
    logic [319:0] s_in;
    logic [319:0] s_out;
    logic [3:0]   idx;
    if (j == 0) begin : g_first
      assign s_in = st_q;
    end else begin : g_chain
      assign s_in = g_stage[j-1].s_out;
    end
    assign idx         = k_q + 4'(j);
    assign stage_rc[j] = {~idx, idx};
    assign s_out       = (4'(j) < rem_q) ? ascon_round(s_in, stage_rc[j]) : s_in;
  end

  assign stage_last = g_stage[UNROLL-1].s_out;

  always_comb begin
    a_clamped = in_rounds;
    if (in_rounds == 4'd0 || in_rounds > 4'd12) a_clamped = 4'd12;
    m        = (rem_q < 4'(UNROLL)) ? rem_q : 4'(UNROLL);
    rem_next = rem_q - m;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      st_q        <= '0;
      k_q         <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            st_q    <= in_state;
            k_q     <= 4'd12 - a_clamped;
            rem_q   <= a_clamped;
            state_q <= StRun;
          end
        end
        StRun: begin
          st_q  <= stage_last;
          k_q   <= k_q + m;
          rem_q <= rem_next;
          if (rem_next == 4'd0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = !in_ready;
  assign out_valid = out_valid_q;
  assign out_state = st_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: one instance per UNROLL value, checked against a table-driven
// S-box reference of the Ascon permutation.
module tb_ascon_perm_core;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [319:0] in_state  [4];
  logic [319:0] out_state [4];
  logic [3:0]   in_rounds [4];

  for (genvar u = 0; u < 4; u++) begin : g_dut
    ascon_perm_core #(.UNROLL(u + 1), .BW(64)) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid[u]),
      .in_ready (in_ready[u]),
      .in_state (in_state[u]),
      .in_rounds(in_rounds[u]),
      .out_valid(out_valid[u]),
      .out_ready(out_ready[u]),
      .out_state(out_state[u]),
      .busy     (busy[u])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] trace [$];

  function automatic logic [4:0] sbox5(input logic [4:0] i);
    case (i)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int k);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    int r1, r2;
    for (int l = 0; l < 5; l++) x[l] = s[319-64*l -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - k) << 4) | k);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = sbox5(col);
      for (int l = 0; l < 5; l++) y[l][b] = o[4-l];
    end
    for (int l = 0; l < 5; l++) begin
      case (l)
        0: begin r1 = 19; r2 = 28; end
        1: begin r1 = 61; r2 = 39; end
        2: begin r1 = 1;  r2 = 6;  end
        3: begin r1 = 10; r2 = 17; end
        default: begin r1 = 7; r2 = 41; end
      endcase
      for (int i = 0; i < 64; i++)
        x[l][i] = y[l][i] ^ y[l][(i + r1) % 64] ^ y[l][(i + r2) % 64];
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int clamp(input logic [3:0] a);
    return (a == 4'd0 || a > 4'd12) ? 12 : int'(a);
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
    logic [319:0] r = s;
    for (int k = 12 - a; k < 12; k++) r = model_round(r, k);
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int w = 0; w < 10; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Returns at the negedge following the acceptance edge.
  task automatic launch(input int u, input logic [319:0] st, input logic [3:0] a,
                        output logic accepted);
    @(negedge clk);
    in_state[u]  = st;
    in_rounds[u] = a;
    in_valid[u]  = 1'b1;
    accepted     = in_ready[u];
    @(negedge clk);
    in_valid[u]  = 1'b0;
  endtask

  task automatic wait_out(input int u, output int lat);
    lat = 0;
    trace.delete();
    while (!out_valid[u] && lat < 40) begin
      if (u == 0 && busy[0]) trace.push_back(g_dut[0].u_dut.stage_rc[0]);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out(input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl u=%0d: got rdy=%b vld=%b busy=%b want 1 0 0",
                 u, in_ready[u], out_valid[u], busy[u]);
      end
      checks++;
      if (out_state[u] !== 320'd0) begin
        errors++;
        $display("FAIL reset_state u=%0d: got %h want 0", u, out_state[u]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic acc;
    int seen;
    launch(0, rand_state(), 4'd12, acc);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_state[0] !== 320'd0) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b rdy=%b state=%h want 0 1 0",
               out_valid[0], in_ready[0], out_state[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d out_valid cycles want 0", seen);
    end
  endtask

  task automatic test_p12_zero();
    logic acc;
    int lat;
    logic [319:0] exp;
    logic [7:0] rc_exp;
    exp = model_perm(320'd0, 12);
    launch(0, 320'd0, 4'd12, acc);
    wait_out(0, lat);
    checks++;
    if (!acc || lat != 12) begin
      errors++;
      $display("FAIL p12_latency: got acc=%b lat=%0d want 1 12", acc, lat);
    end
    checks++;
    if (out_state[0] !== exp) begin
      errors++;
      $display("FAIL p12_zero: got %h want %h", out_state[0], exp);
    end
    checks++;
    if (trace.size() != 12) begin
      errors++;
      $display("FAIL p12_trace_len: got %0d want 12", trace.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        rc_exp = 8'(((15 - i) << 4) | i);
        checks++;
        if (trace[i] !== rc_exp) begin
          errors++;
          $display("FAIL p12_const[%0d]: got %h want %h", i, trace[i], rc_exp);
        end
      end
    end
    release_out(0);
  endtask

  task automatic test_p6_p8();
    logic acc;
    int lat, a, want_lat;
    logic [319:0] st, exp;
    for (int u = 0; u < 4; u++) begin
      for (int t = 0; t < 2; t++) begin
        a = (t == 0) ? 6 : 8;
        want_lat = (a + u) / (u + 1);
        st  = rand_state();
        exp = model_perm(st, a);
        launch(u, st, 4'(a), acc);
        wait_out(u, lat);
        checks++;
        if (!acc || lat != want_lat) begin
          errors++;
          $display("FAIL p%0d_latency u=%0d: got lat=%0d want %0d", a, u + 1, lat, want_lat);
        end
        checks++;
        if (out_state[u] !== exp) begin
          errors++;
          $display("FAIL p%0d_result u=%0d: got %h want %h", a, u + 1, out_state[u], exp);
        end
        if (u == 0) begin
          checks++;
          if (trace.size() == 0 || trace[0] !== ((a == 6) ? 8'h96 : 8'hb4)) begin
            errors++;
            $display("FAIL p%0d_first_const: got %h want %h", a,
                     (trace.size() == 0) ? 8'hxx : trace[0], (a == 6) ? 8'h96 : 8'hb4);
          end
        end
        release_out(u);
      end
    end
  endtask

  task automatic test_clamp();
    logic acc;
    int lat, want_lat;
    logic [3:0] rin;
    logic [319:0] st, exp;
    for (int u = 0; u < 4; u += 3) begin
      for (int t = 0; t < 2; t++) begin
        rin = (t == 0) ? 4'd0 : 4'd15;
        want_lat = (12 + u) / (u + 1);
        st  = rand_state();
        exp = model_perm(st, 12);
        launch(u, st, rin, acc);
        wait_out(u, lat);
        checks++;
        if (lat != want_lat || out_state[u] !== exp) begin
          errors++;
          $display("FAIL clamp a=%0d u=%0d: got lat=%0d %h want lat=%0d %h",
                   rin, u + 1, lat, out_state[u], want_lat, exp);
        end
        release_out(u);
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int lat;
    logic [319:0] st, exp;
    st  = rand_state();
    exp = model_perm(st, 6);
    launch(1, st, 4'd6, acc);
    wait_out(1, lat);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || out_state[1] !== exp) begin
        errors++;
        $display("FAIL backpressure c=%0d: got vld=%b rdy=%b %h want 1 0 %h",
                 c, out_valid[1], in_ready[1], out_state[1], exp);
      end
      in_valid[1] = (c == 3 || c == 4);
      in_state[1] = ~st;
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    release_out(1);
    checks++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || out_state[1] !== exp) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b %h want 1 0 %h",
               in_ready[1], out_valid[1], out_state[1], exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [319:0] exp_q [$];
    logic [319:0] cur_st, exp;
    logic [3:0] cur_a;
    int sent, done, cyc;
    for (int u = 0; u < 4; u++) begin
      exp_q.delete();
      sent = 0;
      done = 0;
      cyc  = 0;
      cur_st = rand_state();
      cur_a  = 4'($urandom_range(0, 15));
      while (done < 25 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        out_ready[u] = 1'($urandom_range(0, 1));
        if (out_valid[u] && out_ready[u]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_extra u=%0d: got %h want no result", u + 1, out_state[u]);
          end else begin
            exp = exp_q.pop_front();
            if (out_state[u] !== exp) begin
              errors++;
              $display("FAIL b2b_result u=%0d job=%0d: got %h want %h",
                       u + 1, done, out_state[u], exp);
            end
          end
          done++;
        end
        if (sent < 25) begin
          in_valid[u]  = 1'b1;
          in_state[u]  = cur_st;
          in_rounds[u] = cur_a;
          if (in_ready[u]) begin
            exp_q.push_back(model_perm(cur_st, clamp(cur_a)));
            sent++;
            cur_st = rand_state();
            cur_a  = 4'($urandom_range(0, 15));
          end
        end else begin
          in_valid[u] = 1'b0;
        end
      end
      @(negedge clk);
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      checks++;
      if (done != 25 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL b2b_count u=%0d: got done=%0d pending=%0d want 25 0",
                 u + 1, done, exp_q.size());
      end
    end
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    for (int u = 0; u < 4; u++) begin
      in_state[u]  = '0;
      in_rounds[u] = 4'd12;
    end
    test_reset();
    test_reset_mid();
    test_p12_zero();
    test_p6_p8();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
